// File: rtl/vga_cap_pkg.sv
// Shared definitions for the VGA pixel capture front end.
//  - state_t     : capture FSM state encoding (exported on the top's fsm_state port)
//  - pixel_width : packed pixel width for a given bytes-per-pixel count
//  - entry_width : FIFO entry width; entry layout is {sof, eol, pixel}
package vga_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  function automatic int pixel_width(input int bytes_per_pixel);
    return 8 * bytes_per_pixel;
  endfunction

  // sof sits in the MSB, eol just below it, pixel in the low PIXEL_W bits.
  function automatic int entry_width(input int bytes_per_pixel);
    return 8 * bytes_per_pixel + 2;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a fall-through head and count-based full/empty.
// Ports:
//  p_clk, RST        clock, asynchronous active-low reset
//  wr_en, wr_data    write request; taken when not full, or when full and a read
//                    happens in the same cycle
//  rd_en             pop the head; ignored while empty
//  rd_data           current head entry (only meaningful while !empty)
//  empty, full       occupancy flags
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             p_clk,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // When full, wr_ptr equals rd_ptr: the head is read combinationally this
  // cycle and overwritten at the edge, so push+pop on a full FIFO is safe.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge p_clk or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge p_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vga_pixel_capture.sv
// Camera-side VGA capture front end.
// Samples the 8-bit sensor bus, packs BYTES_PER_PIXEL bytes MSB-first into a
// pixel, tags it with start-of-frame / end-of-line, and queues it in a FIFO.
// Ports:
//  p_clk, RST     pixel clock, asynchronous active-low reset
//  v_sync         high = vertical blanking
//  h_sync         high = active line byte on i_data
//  i_data         sensor byte
//  o_data         packed pixel at FIFO head (0 while o_valid is low)
//  o_sof, o_eol   head tags: pixel (0,0) / last pixel of its line
//  o_valid        FIFO head valid
//  i_ready        consumer ready
//  o_overflow     sticky: a pixel was dropped on a full FIFO; cleared at frame start
//  o_line_err     1-cycle pulse: partial pixel at line end, or over-long line
//  o_frame_err    1-cycle pulse: frame ended with line count != V_ACTIVE
//  fsm_state      current capture FSM state (state_t encoding)
// Handshake: a head entry transfers on every rising edge where o_valid and
// i_ready are both high; o_data/o_sof/o_eol are stable until that transfer,
// and i_ready may be high while o_valid is low without effect.
module vga_pixel_capture
  import vga_cap_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int FIFO_DEPTH      = 4,
  localparam int PIXEL_W        = pixel_width(BYTES_PER_PIXEL)
) (
  input  logic               p_clk,
  input  logic               RST,
  input  logic               v_sync,
  input  logic               h_sync,
  input  logic [7:0]         i_data,
  output logic [PIXEL_W-1:0] o_data,
  output logic               o_sof,
  output logic               o_eol,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_overflow,
  output logic               o_line_err,
  output logic               o_frame_err,
  output logic [1:0]         fsm_state
);

  localparam int BC_W = $clog2(BYTES_PER_PIXEL + 1);
  localparam int X_W  = $clog2(H_ACTIVE + 1);
  localparam int Y_W  = $clog2(V_ACTIVE + 1);
  localparam int E_W  = entry_width(BYTES_PER_PIXEL);
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  // ---------------- FSM ----------------
  state_t state, state_n;
  logic   frame_start;
  logic   frame_end;

  always_ff @(posedge p_clk or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  // S_VBLANK is only entered with v_sync high, so v_sync low there is the
  // falling edge that opens a frame.
  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE:   if (v_sync) state_n = S_VBLANK;
      S_VBLANK: if (!v_sync) begin
        state_n     = S_ACTIVE;
        frame_start = 1'b1;
      end
      S_ACTIVE: if (v_sync) begin
        state_n   = S_VBLANK;
        frame_end = 1'b1;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  assign fsm_state = state;

  // ---------------- Datapath ----------------
  logic [PIXEL_W-1:0] pix_buf;
  logic [PIXEL_W-1:0] pix_word;
  logic [BC_W-1:0]    byte_cnt;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               hs_q;
  logic               sof_pending;
  logic               long_seen;
  logic               accept;
  logic               hs_fall;
  logic               pix_done;
  logic               in_range;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [E_W-1:0]     entry;
  logic [E_W-1:0]     head;

  assign accept   = (state == S_ACTIVE) && h_sync;
  assign hs_fall  = (state == S_ACTIVE) && hs_q && !h_sync;
  assign pix_done = accept && (byte_cnt == BC_W'(BYTES_PER_PIXEL - 1));
  assign in_range = (x < X_W'(H_ACTIVE));
  assign push     = pix_done && in_range;

  // Drop the incoming byte into its lane; on the last byte this is the
  // complete pixel that gets written to the FIFO.
  always_comb begin
    pix_word = pix_buf;
    for (int b = 0; b < BYTES_PER_PIXEL; b++) begin
      if (byte_cnt == BC_W'(b)) pix_word[PIXEL_W-1-8*b -: 8] = i_data;
    end
  end

  assign entry = {sof_pending, (x == X_W'(H_ACTIVE - 1)), pix_word};

  always_ff @(posedge p_clk or negedge RST) begin
    if (!RST) begin
      pix_buf     <= '0;
      byte_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      hs_q        <= 1'b0;
      sof_pending <= 1'b0;
      long_seen   <= 1'b0;
      o_overflow  <= 1'b0;
      o_line_err  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      hs_q        <= h_sync;
      o_line_err  <= 1'b0;
      o_frame_err <= frame_end && (y != Y_W'(V_ACTIVE));
      if (frame_start) begin
        x           <= '0;
        y           <= '0;
        byte_cnt    <= '0;
        sof_pending <= 1'b1;
        long_seen   <= 1'b0;
        o_overflow  <= 1'b0;
      end else if (hs_fall) begin
        if (y != Y_MAX) y <= y + Y_W'(1);
        x          <= '0;
        byte_cnt   <= '0;
        long_seen  <= 1'b0;
        o_line_err <= (byte_cnt != '0);
      end else if (accept) begin
        pix_buf <= pix_word;
        if (pix_done) begin
          byte_cnt <= '0;
          if (x != X_MAX) x <= x + X_W'(1);
          // Only the first out-of-range pixel of a line raises the error.
          if (!in_range && !long_seen) begin
            o_line_err <= 1'b1;
            long_seen  <= 1'b1;
          end
          if (push) begin
            // A pop on a full FIFO frees the slot this edge, so only full
            // without ready loses the pixel.
            if (fifo_full && !i_ready) o_overflow  <= 1'b1;
            else                       sof_pending <= 1'b0;
          end
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end
    end
  end

  pixel_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .p_clk   (p_clk),
    .RST     (RST),
    .wr_en   (push),
    .wr_data (entry),
    .rd_en   (i_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = o_valid ? head[PIXEL_W-1:0] : '0;
  assign o_eol   = o_valid && head[PIXEL_W];
  assign o_sof   = o_valid && head[PIXEL_W+1];

endmodule

// File: tb/tb_vga_pixel_capture.sv
// Bench for vga_pixel_capture with BPP=2, H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4.
module tb_vga_pixel_capture;

  localparam int BPP   = 2;
  localparam int HA    = 4;
  localparam int VA    = 2;
  localparam int DEPTH = 4;
  localparam int PW    = 8 * BPP;
  localparam int EW    = PW + 2;

  logic          p_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v_sync = 1'b0;
  logic          h_sync = 1'b0;
  logic          i_ready = 1'b0;
  logic [7:0]    i_data = 8'h00;
  logic [PW-1:0] o_data;
  logic          o_sof, o_eol, o_valid, o_overflow, o_line_err, o_frame_err;
  logic [1:0]    fsm_state;

  always #5 p_clk = ~p_clk;

  vga_pixel_capture #(
    .BYTES_PER_PIXEL (BPP),
    .H_ACTIVE        (HA),
    .V_ACTIVE        (VA),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .p_clk       (p_clk),
    .RST         (rst_n),
    .v_sync      (v_sync),
    .h_sync      (h_sync),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overflow  (o_overflow),
    .o_line_err  (o_line_err),
    .o_frame_err (o_frame_err),
    .fsm_state   (fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int lerr_cnt = 0;
  int ferr_cnt = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic       new_frame;
    logic       end_frame;
    int         nbytes;
    logic [7:0] first;
    int         exp_pix;
    int         exp_lerr;
    int         exp_ferr;
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Scoreboard / monitor ----------------
  always @(negedge p_clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) begin
        logic [EW-1:0] exp_e;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pixel_unexpected: got %0h expected none", {o_sof, o_eol, o_data});
        end else begin
          exp_e = exp_q.pop_front();
          check("pixel", {14'd0, o_sof, o_eol, o_data}, {14'd0, exp_e});
        end
      end
      if (o_line_err)  lerr_cnt++;
      if (o_frame_err) ferr_cnt++;
    end
  end

  // ---------------- Driver tasks ----------------
  task automatic cycle();
    @(posedge p_clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input logic [7:0] first, input int i);
    return first + 8'(i * 17);
  endfunction

  task automatic frame_start();
    v_sync = 1'b1;
    repeat (3) cycle();
    v_sync = 1'b0;
    repeat (2) cycle();
  endtask

  // rmode 0: leave i_ready alone; rmode 1: ready only on odd bytes
  // (the edges that complete a pixel).
  task automatic drive_line(input logic [7:0] first, input int nbytes, input int rmode);
    for (int i = 0; i < nbytes; i++) begin
      h_sync = 1'b1;
      i_data = byte_at(first, i);
      if (rmode == 1) i_ready = (i % 2 == 1);
      cycle();
    end
    h_sync = 1'b0;
    if (rmode == 1) i_ready = 1'b0;
    repeat (4) cycle();
  endtask

  // Expected pixels of one line: bytes pair up MSB first, pixels beyond
  // HA are dropped, sof on the frame's first pixel, eol on pixel HA-1.
  task automatic expect_line(input logic [7:0] first, input int nbytes, input logic first_line);
    for (int k = 0; k < nbytes / 2 && k < HA; k++) begin
      exp_q.push_back({(first_line && k == 0), (k == HA - 1),
                       byte_at(first, 2 * k), byte_at(first, 2 * k + 1)});
    end
  endtask

  initial begin
    rows[0] = '{1'b1, 1'b0, 8,  8'h11, 4, 0, 0};
    rows[1] = '{1'b0, 1'b1, 8,  8'h99, 4, 0, 0};
    rows[2] = '{1'b1, 1'b0, 7,  8'h10, 3, 1, 0};
    rows[3] = '{1'b0, 1'b1, 10, 8'h20, 4, 1, 0};
    rows[4] = '{1'b1, 1'b1, 8,  8'h30, 4, 0, 1};
    rows[5] = '{1'b1, 1'b0, 8,  8'h40, 4, 0, 0};
    rows[6] = '{1'b0, 1'b1, 8,  8'h50, 4, 0, 0};

    // ---- reset state ----
    repeat (3) cycle();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_sof", o_sof, 0);
    check("rst_eol", o_eol, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_line_err", o_line_err, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;
    cycle();

    // ---- h_sync activity in S_IDLE is ignored ----
    i_ready = 1'b1;
    pop_cnt = 0;
    drive_line(8'h55, 8, 0);
    check("idle_pops", pop_cnt, 0);
    check("idle_state", fsm_state, 0);
    v_sync = 1'b1;
    cycle();
    check("vblank_state", fsm_state, 1);

    // ---- table-driven frames ----
    for (int r = 0; r < 7; r++) begin
      if (rows[r].new_frame) begin
        frame_start();
        check("active_state", fsm_state, 2);
      end
      pop_cnt  = 0;
      lerr_cnt = 0;
      ferr_cnt = 0;
      expect_line(rows[r].first, rows[r].nbytes, rows[r].new_frame);
      drive_line(rows[r].first, rows[r].nbytes, 0);
      check($sformatf("row%0d_pixels", r), pop_cnt, rows[r].exp_pix);
      check($sformatf("row%0d_line_err", r), lerr_cnt, rows[r].exp_lerr);
      if (rows[r].end_frame) begin
        v_sync = 1'b1;
        repeat (3) cycle();
        check($sformatf("row%0d_frame_err", r), ferr_cnt, rows[r].exp_ferr);
      end
    end

    // ---- overflow: consumer stalled for two lines ----
    frame_start();
    i_ready = 1'b0;
    pop_cnt = 0;
    expect_line(8'h61, 8, 1'b1);
    drive_line(8'h61, 8, 0);
    drive_line(8'h71, 8, 0);
    check("ovf_flag", o_overflow, 1);
    check("ovf_valid", o_valid, 1);
    check("ovf_no_pops", pop_cnt, 0);
    i_ready = 1'b1;
    repeat (6) cycle();
    check("ovf_drained", pop_cnt, 4);
    check("ovf_empty", o_valid, 0);
    v_sync = 1'b1;
    repeat (3) cycle();
    check("ovf_sticky_vblank", o_overflow, 1);
    v_sync = 1'b0;
    repeat (2) cycle();
    check("ovf_cleared", o_overflow, 0);

    // ---- full FIFO with push and pop on the same edge ----
    frame_start();
    i_ready = 1'b0;
    pop_cnt = 0;
    expect_line(8'h81, 8, 1'b1);
    expect_line(8'h91, 8, 1'b0);
    drive_line(8'h81, 8, 0);
    check("full_valid", o_valid, 1);
    drive_line(8'h91, 8, 1);
    check("full_no_ovf", o_overflow, 0);
    check("full_mid_pops", pop_cnt, 4);
    i_ready = 1'b1;
    repeat (6) cycle();
    check("full_total_pops", pop_cnt, 8);
    check("full_empty", o_valid, 0);

    // ---- reset mid-line ----
    frame_start();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h_sync = 1'b1;
      i_data = byte_at(8'hA1, i);
      cycle();
    end
    check("midrst_pre_valid", o_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    cycle();
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_sof", o_sof, 0);
    check("midrst_state", fsm_state, 0);
    rst_n = 1'b1;
    i_ready = 1'b1;
    pop_cnt = 0;
    drive_line(8'hB1, 8, 0);
    check("midrst_ignored", pop_cnt, 0);
    check("midrst_still_idle", o_valid, 0);
    frame_start();
    pop_cnt  = 0;
    lerr_cnt = 0;
    expect_line(8'hC1, 8, 1'b1);
    drive_line(8'hC1, 8, 0);
    check("midrst_resume_pixels", pop_cnt, 4);
    check("midrst_resume_line_err", lerr_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
